seq_subtractor: RTL and testbench

Parametrised multi-cycle subtractor computing DIFF = A − B − BIN over WIDTH-bit operands, DIGIT bits per clock, LSB slice first. A DIGIT-wide ripple of full-subtractor cells computes each slice, and a borrow register carries the borrow between slices. It extends the single-bit full subtractor to wide operands at bounded combinational depth. It adds a start/busy/done handshake and flag outputs (borrow, signed overflow, zero) for use by datapath controllers.

---
 rtl/seq_subtractor.sv | 150 +++++++++++++++
 tb/tb_seq_subtractor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle A - B - BIN, DIGIT bits per clock, LSB slice first.
// A DIGIT-wide ripple of borrow cells handles one slice per cycle. A borrow
// register carries the borrow between slices.
`timescale 1ns/1ps

// One full-subtractor bit: difference and borrow-out.
module seq_sub_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_br,
  output logic o_d,
  output logic o_bo
);
  assign o_d  = i_x ^ i_y ^ i_br;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_br);
endmodule

module seq_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Stop elaboration on a slice width that cannot tile the operand.
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("seq_subtractor: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;
  } res_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;     // operands, shifted right one slice per cycle
  logic [WIDTH-1:0] r_part;       // finished slices, filled from the top down
  logic             r_br;         // borrow into the current slice
  logic [CW-1:0]    r_cnt;
  logic             r_amsb, r_bmsb;
  logic             r_busy, r_done;
  res_t             r_res;

  logic [DIGIT:0]         w_br;
  logic [DIGIT-1:0]       w_d;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_part_next;
  logic                   w_last;
  logic                   w_unused_lsb;
  res_t                   w_res_next;

  // Borrow ripple across the current slice.
  assign w_br[0] = r_br;
  for (genvar j = 0; j < DIGIT; j++) begin : g_cell
    seq_sub_cell u_cell (
      .i_x  (r_a[j]),
      .i_y  (r_b[j]),
      .i_br (w_br[j]),
      .o_d  (w_d[j]),
      .o_bo (w_br[j+1])
    );
  end

  // New slice enters at the top; after N slices slice 0 sits at the LSBs.
  assign w_cat        = {w_d, r_part};
  assign w_part_next  = w_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_unused_lsb = ^w_cat[DIGIT-1:0];
  assign w_last       = (r_cnt == CW'(N - 1));

  // Result flags computed from the completed difference and latched operand MSBs.
  always_comb begin
    w_res_next      = '0;
    w_res_next.diff = w_part_next;
    w_res_next.bout = w_br[DIGIT];
    w_res_next.ovf  = (r_amsb ^ r_bmsb) & (w_part_next[WIDTH-1] ^ r_amsb);
    w_res_next.zero = (w_part_next == '0);
  end

  // Control FSM and datapath; DONE accepts a new start exactly like IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_a    <= r_a >> DIGIT;
          r_b    <= r_b >> DIGIT;
          r_part <= w_part_next;
          r_br   <= w_br[DIGIT];
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_res   <= w_res_next;
          end
        end
        default: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_br    <= i_bin;
            r_amsb  <= i_a[WIDTH-1];
            r_bmsb  <= i_b[WIDTH-1];
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_diff = r_res.diff;
  assign o_bout = r_res.bout;
  assign o_ovf  = r_res.ovf;
  assign o_zero = r_res.zero;
endmodule

// File: tb/tb_seq_subtractor.sv
// Bench for seq_subtractor: directed cases on DIGIT=4, then random operands
// driven into DIGIT=4, DIGIT=1 and DIGIT=16 instances side by side.
`timescale 1ns/1ps

module tb_seq_subtractor;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       start;
  logic [W-1:0]     a, b;
  logic             bin;
  logic [2:0]       busy, done, bout, ovf, zero;
  logic [2:0][W-1:0] diff;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: DIGIT=4, 1: DIGIT=1, 2: DIGIT=16.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    seq_subtractor #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start[g]),
      .i_a     (a),
      .i_b     (b),
      .i_bin   (bin),
      .o_busy  (busy[g]),
      .o_done  (done[g]),
      .o_diff  (diff[g]),
      .o_bout  (bout[g]),
      .o_ovf   (ovf[g]),
      .o_zero  (zero[g])
    );
  end

  // Reference: plain integer arithmetic. Returns {ovf, bout, zero, diff}.
  function automatic logic [18:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    int u, s;
    logic [15:0] d;
    u = int'(x) - int'(y) - int'(c);
    s = int'($signed(x)) - int'($signed(y)) - int'(c);
    d = u[15:0];
    return {(s < -32768 || s > 32767), (u < 0), (d == 16'h0), d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input int g, input string tag, input logic [18:0] e);
    chk({tag, "_diff"}, 32'(diff[g]), 32'(e[15:0]));
    chk({tag, "_zero"}, 32'(zero[g]), 32'(e[16]));
    chk({tag, "_bout"}, 32'(bout[g]), 32'(e[17]));
    chk({tag, "_ovf"},  32'(ovf[g]),  32'(e[18]));
  endtask

  // One operation on instance g; n_exp = edges from accept edge to done.
  task automatic run_op(input int g, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input int n_exp, input string tag);
    logic [18:0] e;
    logic [15:0] prev;
    int n;
    bit seen;
    e    = ref_sub(x, y, c);
    prev = diff[g];
    @(negedge clk); a = x; b = y; bin = c; start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    chk({tag, "_busy_run"}, 32'(busy[g]), 32'd1);
    chk({tag, "_done_run"}, 32'(done[g]), 32'd0);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done[g]) seen = 1;
      else chk({tag, "_hold"}, 32'(diff[g]), 32'(prev));
    end
    chk({tag, "_latency"}, n, n_exp);
    chk({tag, "_busy_done"}, 32'(busy[g]), 32'd0);
    chk_res(g, tag, e);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done[g]), 32'd0);
  endtask

  initial begin
    int n, nd;
    int lat[3];
    logic [15:0] x, y, hold_diff;
    logic c;
    logic [18:0] e;
    logic [15:0] corners[4];
    corners = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

    rst = 1'b1; start = '0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_diff", 32'(diff[0]), 32'd0);
    chk("rst_flags", 32'({bout, ovf}), 32'd0);
    rst = 1'b0;

    // Directed cases from the plan, with literal expectations.
    run_op(0, 16'h1234, 16'h0234, 1'b0, 4, "basic");
    chk("basic_lit", 32'(diff[0]), 32'h1000);
    run_op(0, 16'h0000, 16'h0001, 1'b0, 4, "under");
    chk("under_lit", 32'({diff[0], bout[0], ovf[0]}), {13'd0, 16'hFFFF, 2'b10});
    run_op(0, 16'h8000, 16'h0001, 1'b0, 4, "ovf");
    chk("ovf_lit", 32'({diff[0], bout[0], ovf[0]}), {13'd0, 16'h7FFF, 2'b01});
    run_op(0, 16'h0005, 16'h0005, 1'b1, 4, "binb");
    chk("binb_lit", 32'({diff[0], bout[0], zero[0]}), {13'd0, 16'hFFFF, 2'b10});
    run_op(0, 16'h0005, 16'h0004, 1'b1, 4, "binz");
    chk("binz_lit", 32'({diff[0], bout[0], zero[0]}), {13'd0, 16'h0000, 2'b01});

    // Start during RUN is ignored; start held into DONE launches the next op.
    @(negedge clk); a = 16'h00FF; b = 16'h0001; bin = 1'b0; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk); start[0] = 1'b1; a = 16'h1111; b = 16'h0011;
    n = 0;
    while (!done[0] && n < 20) begin @(negedge clk); n++; end
    chk("ign_latency", n, 3);
    chk("ign_diff", 32'(diff[0]), 32'h00FE);
    @(negedge clk); start[0] = 1'b0;
    chk("b2b_busy", 32'(busy[0]), 32'd1);
    chk("b2b_hold", 32'(diff[0]), 32'h00FE);
    n = 0;
    while (!done[0] && n < 20) begin @(negedge clk); n++; end
    chk("b2b_gap", n + 1, 5);
    chk("b2b_diff", 32'(diff[0]), 32'h1100);

    // Asynchronous reset in the second RUN cycle.
    @(negedge clk); a = 16'h4321; b = 16'h0001; bin = 1'b0; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_outs", 32'({busy[0], done[0], bout[0], ovf[0], zero[0]}), 32'd0);
    chk("arst_diff", 32'(diff[0]), 32'd0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (8) begin @(negedge clk); if (done[0] || busy[0]) nd++; end
    chk("arst_no_done", nd, 0);
    run_op(0, 16'h4321, 16'h0321, 1'b0, 4, "after_rst");
    chk("after_rst_lit", 32'(diff[0]), 32'h4000);

    // Single-op sanity on the other two widths, including latency.
    run_op(1, 16'h1234, 16'h0234, 1'b0, 16, "d1");
    run_op(2, 16'h0000, 16'h0001, 1'b1, 1, "d16");

    // Random (with corner-value prefix) across all three instances at once.
    for (int i = 0; i < 1000; i++) begin
      if (i < 32) begin
        x = corners[i % 4]; y = corners[(i / 4) % 4]; c = 1'(i / 16);
      end else begin
        x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      end
      e = ref_sub(x, y, c);
      @(negedge clk); a = x; b = y; bin = c; start = 3'b111;
      @(negedge clk); start = '0;
      a = 16'($urandom); b = 16'($urandom);
      lat = '{-1, -1, -1};
      n = 0;
      while (n < 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0)) begin
        @(posedge clk); n++;
        @(negedge clk);
        for (int g = 0; g < 3; g++)
          if (done[g] && lat[g] < 0) begin
            lat[g] = n;
            chk_res(g, "rnd", e);
          end
      end
      // Edges after the accept edge: N; start-to-done is N+1 cycles.
      chk("rnd_lat_d4",  lat[0], 4);
      chk("rnd_lat_d1",  lat[1], 16);
      chk("rnd_lat_d16", lat[2], 1);
    end

    hold_diff = diff[1];
    repeat (3) @(negedge clk);
    chk("idle_hold", 32'(diff[1]), 32'(hold_diff));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
